// File: rtl/writeback_unit_if.sv
// Bundle of the writeback stage's producer handshakes, issue-side scoreboard
// signals and the register file write port.
interface writeback_unit_if #(
  parameter int REG_COUNT = 32,
  parameter int REG_WIDTH = 32
);
  localparam int IDX_W = $clog2(REG_COUNT);

  logic                 alu_valid;
  logic                 alu_ready;
  logic [IDX_W-1:0]     alu_rd;
  logic [REG_WIDTH-1:0] alu_value;
  logic                 load_valid;
  logic                 load_ready;
  logic [IDX_W-1:0]     load_rd;
  logic [REG_WIDTH-1:0] load_value;
  logic                 issue_load;
  logic [IDX_W-1:0]     issue_rd;
  logic [REG_COUNT-1:0] busy;
  logic [IDX_W-1:0]     rd;
  logic [REG_WIDTH-1:0] rd_value;
  logic                 wr_en;

  // Producers and the issue stage drive the master side; the writeback unit is the slave.
  modport master (
    output alu_valid, alu_rd, alu_value,
    output load_valid, load_rd, load_value,
    output issue_load, issue_rd,
    input  alu_ready, load_ready, busy, rd, rd_value, wr_en
  );

  modport slave (
    input  alu_valid, alu_rd, alu_value,
    input  load_valid, load_rd, load_value,
    input  issue_load, issue_rd,
    output alu_ready, load_ready, busy, rd, rd_value, wr_en
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and FIFO-buffered load responses onto the
// single register file write port and tracks outstanding loads per register.
module writeback_unit #(
  parameter int REG_COUNT       = 32,
  parameter int REG_WIDTH       = 32,
  parameter int LOAD_FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave bus
);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int PTR_W = $clog2(LOAD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]     fifo_rd    [LOAD_FIFO_DEPTH];
  logic [REG_WIDTH-1:0] fifo_value [LOAD_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic [IDX_W-1:0]     rd_q;
  logic [REG_WIDTH-1:0] rd_value_q;
  logic                 wr_en_q;
  logic [REG_COUNT-1:0] busy_q, busy_next;

  logic fifo_full, fifo_empty, push, pop, take_alu;
  logic [IDX_W-1:0]     head_rd;
  logic [REG_WIDTH-1:0] head_value;

  // A full FIFO preempts the ALU so load responses can never deadlock behind it.
  always_comb begin
    fifo_full  = (count == CNT_W'(LOAD_FIFO_DEPTH));
    fifo_empty = (count == '0);
    head_rd    = fifo_rd[rd_ptr];
    head_value = fifo_value[rd_ptr];
    bus.load_ready = !reset && !fifo_full;
    bus.alu_ready  = !reset && !fifo_full;
    push     = bus.load_valid && bus.load_ready;
    pop      = fifo_full || (!bus.alu_valid && !fifo_empty);
    take_alu = bus.alu_valid && bus.alu_ready;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]    <= bus.load_rd;
      fifo_value[wr_ptr] <= bus.load_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Writes to x0 still consume their source but never assert the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= '0;
      rd_value_q <= '0;
      wr_en_q    <= 1'b0;
    end else if (pop) begin
      rd_q       <= head_rd;
      rd_value_q <= head_value;
      wr_en_q    <= (head_rd != '0);
    end else if (take_alu) begin
      rd_q       <= bus.alu_rd;
      rd_value_q <= bus.alu_value;
      wr_en_q    <= (bus.alu_rd != '0);
    end else begin
      wr_en_q    <= 1'b0;
    end
  end

  // Clear is applied before set so a same-register collision leaves the bit set.
  always_comb begin
    busy_next = busy_q;
    if (pop && head_rd != '0) busy_next[head_rd] = 1'b0;
    if (bus.issue_load && bus.issue_rd != '0) busy_next[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_next;
  end

  assign bus.rd       = rd_q;
  assign bus.rd_value = rd_value_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_writeback_unit;
  localparam int REG_COUNT = 32;
  localparam int REG_WIDTH = 32;
  localparam int DEPTH     = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  entry_t      mq[$];
  logic [31:0] mbusy = '0;
  bit          exp_wr_en = 1'b0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_value = '0;

  writeback_unit_if #(.REG_COUNT(REG_COUNT), .REG_WIDTH(REG_WIDTH)) bus ();

  writeback_unit #(
    .REG_COUNT(REG_COUNT), .REG_WIDTH(REG_WIDTH), .LOAD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // One clock of stimulus; the model applies the priority rules to a plain queue.
  task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [31:0] aval,
                               input bit lv, input logic [4:0] lrd, input logic [31:0] lval,
                               input bit iss, input logic [4:0] ird);
    bit full, can_push, do_pop, legal;
    entry_t e;
    @(negedge clk);
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_value = aval;
    bus.load_valid = lv; bus.load_rd = lrd; bus.load_value = lval;
    bus.issue_load = iss; bus.issue_rd = ird;
    #1;
    full     = (mq.size() == DEPTH);
    can_push = lv && !full;
    do_pop   = full || (!av && mq.size() != 0);
    checkOutput("load_ready", bus.load_ready, !full);
    checkOutput("alu_ready", bus.alu_ready, !full);
    legal = !(iss && ird != 0 && mbusy[ird]) || (do_pop && mq[0].rd == ird);
    assert (legal) else $error("[TB] issue_load to busy register %0d", ird);
    if (do_pop) begin
      e = mq.pop_front();
      exp_wr_en = (e.rd != 0); exp_rd = e.rd; exp_value = e.value;
      if (e.rd != 0) mbusy[e.rd] = 1'b0;
    end else if (av) begin
      exp_wr_en = (ard != 0); exp_rd = ard; exp_value = aval;
    end else begin
      exp_wr_en = 1'b0;
    end
    if (can_push) mq.push_back('{rd: lrd, value: lval});
    if (iss && ird != 0) mbusy[ird] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wr_en", bus.wr_en, exp_wr_en);
    if (exp_wr_en) begin
      checkOutput("rd", bus.rd, exp_rd);
      checkOutput("rd_value", bus.rd_value, exp_value);
    end
    checkOutput("busy", bus.busy, mbusy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    bus.alu_valid = 0; bus.load_valid = 0; bus.issue_load = 0;
    #1;
    checkOutput("rst_load_ready", bus.load_ready, 0);
    checkOutput("rst_alu_ready", bus.alu_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("rst_wr_en", bus.wr_en, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_rd", bus.rd, 0);
    checkOutput("rst_rd_value", bus.rd_value, 0);
    mq.delete();
    mbusy = '0;
    exp_wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_load_ready", bus.load_ready, 1);
    checkOutput("post_rst_alu_ready", bus.alu_ready, 1);
  endtask

  initial begin
    logic [4:0] r;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_value = 0;
    bus.load_valid = 0; bus.load_rd = 0; bus.load_value = 0;
    bus.issue_load = 0; bus.issue_rd = 0;
    applyReset();

    // ALU-only stream
    applyStimulus(1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    checkOutput("alu_rd5", bus.rd, 5);
    checkOutput("alu_val5", bus.rd_value, 32'hA5A5A5A5);
    applyStimulus(1, 6, 32'h1, 0, 0, 0, 0, 0);
    checkOutput("alu_rd6", bus.rd, 6);
    idle(1);

    // Load buffered behind three ALU results
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
    checkOutput("busy7_set", bus.busy[7], 1);
    applyStimulus(1, 10, 32'h10, 1, 7, 32'hDEADBEEF, 0, 0);
    applyStimulus(1, 11, 32'h11, 0, 0, 0, 0, 0);
    applyStimulus(1, 12, 32'h12, 0, 0, 0, 0, 0);
    checkOutput("alu_before_load", bus.rd, 12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("load7_rd", bus.rd, 7);
    checkOutput("load7_val", bus.rd_value, 32'hDEADBEEF);
    checkOutput("busy7_clr", bus.busy[7], 0);

    // FIFO fills under continuous ALU traffic, then drains with priority
    for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'(i));
    for (int i = 1; i <= 4; i++) applyStimulus(1, 20, 32'(i), 1, 5'(i), 32'h100 + 32'(i), 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 21, 32'h200 + 32'(i), 0, 0, 0, 0, 0);
    idle(2);

    // x0 filtering
    applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 32'h12345678, 1, 0);
    checkOutput("busy0", bus.busy[0], 0);
    idle(2);

    // Set/clear collision on rd=9, then retire the second load
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
    applyStimulus(1, 13, 32'h13, 1, 9, 32'h99, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
    checkOutput("busy9_kept", bus.busy[9], 1);
    applyStimulus(1, 14, 32'h14, 1, 9, 32'h9A, 0, 0);
    idle(2);

    // Reset with loads queued
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'(i));
    for (int i = 1; i <= 3; i++) applyStimulus(1, 15, 32'(i), 1, 5'(i), 32'h300 + 32'(i), 0, 0);
    checkOutput("busy_0e", bus.busy, 32'h0000000E);
    applyReset();
    idle(4);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r = 5'($urandom);
      applyStimulus($urandom_range(0, 99) < 50, 5'($urandom), $urandom,
                    $urandom_range(0, 99) < 40, 5'($urandom), $urandom,
                    ($urandom_range(0, 99) < 30) && !mbusy[r], r);
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
